// File: rtl/rx_logic_arbiter.sv
// Round-robin arbiter: grants the first requesting port at or above ptr,
// wrapping modulo N.
module rr_arbiter #(
  parameter int N  = 5,
  parameter int PW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          valid,
  output logic [PW-1:0] grant
);

  localparam int unsigned NU = N;

  // Scan N positions starting at ptr; the first pending one wins.
  always_comb begin
    int unsigned idx;
    valid = 1'b0;
    grant = '0;
    idx   = 0;
    for (int unsigned i = 0; i < NU; i++) begin
      idx = (32'(ptr) + i) % NU;
      if (!valid && req[PW'(idx)]) begin
        valid = 1'b1;
        grant = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/rx_logic.sv
// Receive side of the 2-phase transceiver links: synchronizes each port's
// request, arbitrates round-robin among pending ports and writes the granted
// flit into the downstream fifo, acknowledging by toggling that port's ack.
module rx_logic #(
  parameter int ID          = -1,
  parameter int SIZE        = 8,
  parameter int PORT_COUNT  = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [PORT_COUNT-1:0]        fifo_push_req,
  output logic [PORT_COUNT-1:0]        fifo_push_ack,
  input  logic [PORT_COUNT*SIZE-1:0]   fifo_push_data,
  output logic                         fifo_write,
  input  logic                         fifo_full,
  output logic [SIZE-1:0]              fifo_item_in
);

  localparam int PW = (PORT_COUNT > 1) ? $clog2(PORT_COUNT) : 1;

  logic [PORT_COUNT-1:0] req_s;
  logic [PORT_COUNT-1:0] pending;
  logic [PW-1:0]         rr;
  logic [PW-1:0]         grant;
  logic                  grant_valid;
  logic [SIZE-1:0]       slice [PORT_COUNT];

  // ID only tags this instance in simulation debug output.
  logic unused_id;
  assign unused_id = ^ID;

  for (genvar s = 0; s < SYNC_STAGES; s++) begin : g_sync
    logic [PORT_COUNT-1:0] q;
    if (s == 0) begin : g_first
      // First synchronizer stage samples the asynchronous request lines.
      always_ff @(posedge clk) begin
        if (!reset) q <= '0;
        else        q <= fifo_push_req;
      end
    end else begin : g_next
      // Later stages shift the previous stage along.
      always_ff @(posedge clk) begin
        if (!reset) q <= '0;
        else        q <= g_sync[s-1].q;
      end
    end
  end

  assign req_s   = g_sync[SYNC_STAGES-1].q;
  assign pending = req_s ^ fifo_push_ack;

  for (genvar k = 0; k < PORT_COUNT; k++) begin : g_slice
    assign slice[k] = fifo_push_data[SIZE*k +: SIZE];
  end

  rr_arbiter #(
    .N  (PORT_COUNT),
    .PW (PW)
  ) u_arb (
    .req   (pending),
    .ptr   (rr),
    .valid (grant_valid),
    .grant (grant)
  );

  // Write strobe and flit select are combinational; data is never registered.
  always_comb begin
    fifo_write   = reset & grant_valid & ~fifo_full;
    fifo_item_in = slice[0];
    if (fifo_write) fifo_item_in = slice[grant];
  end

  // On each write, acknowledge the granted port and move the pointer past it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fifo_push_ack <= '0;
      rr            <= '0;
    end else if (fifo_write) begin
      fifo_push_ack[grant] <= ~fifo_push_ack[grant];
      if (grant == PW'(PORT_COUNT - 1)) rr <= '0;
      else                              rr <= grant + PW'(1);
    end
  end

endmodule

// File: tb/tb_rx_logic.sv
// Directed bench for rx_logic: a per-cycle vector table for the single-flit,
// contention, wrap and backpressure sequences, followed by hand-written
// mid-operation reset and fairness sequences.
module tb_rx_logic;

  localparam int SIZE = 8;
  localparam int PC   = 5;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [PC-1:0]     req = '0;
  logic [PC-1:0]     ack;
  logic [PC*SIZE-1:0] data;
  logic              fifo_write;
  logic              fifo_full = 1'b0;
  logic [SIZE-1:0]   item;

  logic [7:0] port_data [PC];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rx_logic #(
    .ID          (3),
    .SIZE        (SIZE),
    .PORT_COUNT  (PC),
    .SYNC_STAGES (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .fifo_push_req  (req),
    .fifo_push_ack  (ack),
    .fifo_push_data (data),
    .fifo_write     (fifo_write),
    .fifo_full      (fifo_full),
    .fifo_item_in   (item)
  );

  typedef struct {
    logic [PC-1:0] tog;
    logic          full;
    logic          wr;
    logic [7:0]    itm;
    logic [PC-1:0] ack;
  } vec_t;

  vec_t vecs [25];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic void setv(input int i, input logic [PC-1:0] tog, input logic full,
                               input logic wr, input logic [7:0] itm, input logic [PC-1:0] a);
    vecs[i].tog  = tog;
    vecs[i].full = full;
    vecs[i].wr   = wr;
    vecs[i].itm  = itm;
    vecs[i].ack  = a;
  endfunction

  initial begin
    int cnt [PC];
    int tog_cyc [PC];
    int p;

    port_data[0] = 8'h10;
    port_data[1] = 8'h11;
    port_data[2] = 8'h5A;
    port_data[3] = 8'h33;
    port_data[4] = 8'h14;
    for (int k = 0; k < PC; k++) data[SIZE*k +: SIZE] = port_data[k];

    // Contention on ports 0,1,4 from rr=0.
    setv( 0, 5'b10011, 0, 0, 8'h00, 5'b00000);
    setv( 1, 5'b00000, 0, 0, 8'h00, 5'b00000);
    setv( 2, 5'b00000, 0, 1, 8'h10, 5'b00000);
    setv( 3, 5'b00000, 0, 1, 8'h11, 5'b00001);
    setv( 4, 5'b00000, 0, 1, 8'h14, 5'b00011);
    // Ports 0 and 4 together: port 0 first proves rr wrapped to 0.
    setv( 5, 5'b10001, 0, 0, 8'h00, 5'b10011);
    setv( 6, 5'b00000, 0, 0, 8'h00, 5'b10011);
    setv( 7, 5'b00000, 0, 1, 8'h10, 5'b10011);
    setv( 8, 5'b00000, 0, 1, 8'h14, 5'b10010);
    // Single flit on port 2.
    setv( 9, 5'b00100, 0, 0, 8'h00, 5'b00010);
    setv(10, 5'b00000, 0, 0, 8'h00, 5'b00010);
    setv(11, 5'b00000, 0, 1, 8'h5A, 5'b00010);
    setv(12, 5'b00000, 0, 0, 8'h00, 5'b00110);
    // Port 3 pending under 10 cycles of backpressure.
    setv(13, 5'b01000, 1, 0, 8'h00, 5'b00110);
    for (int i = 14; i < 23; i++) setv(i, 5'b00000, 1, 0, 8'h00, 5'b00110);
    setv(23, 5'b00000, 0, 1, 8'h33, 5'b00110);
    setv(24, 5'b00000, 0, 0, 8'h00, 5'b01110);

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    chk("reset_write", fifo_write, 1'b0);
    chk("reset_ack", ack, 5'b00000);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("post_reset_write", fifo_write, 1'b0);
    chk("post_reset_ack", ack, 5'b00000);

    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      req       = req ^ vecs[i].tog;
      fifo_full = vecs[i].full;
      #1;
      chk($sformatf("vec%0d_write", i), fifo_write, vecs[i].wr);
      chk($sformatf("vec%0d_ack", i), ack, vecs[i].ack);
      if (vecs[i].wr) chk($sformatf("vec%0d_item", i), item, vecs[i].itm);
    end

    // Reset while ports 1 and 2 are pending.
    @(negedge clk);
    req = req ^ 5'b00110;
    #1;
    chk("mid_pre0_write", fifo_write, 1'b0);
    @(negedge clk);
    #1;
    chk("mid_pre1_write", fifo_write, 1'b0);
    @(negedge clk);
    #1;
    chk("mid_pending_write", fifo_write, 1'b1);
    reset = 1'b0;
    req   = '0;
    #1;
    chk("mid_reset_write_forced", fifo_write, 1'b0);
    @(negedge clk);
    #1;
    chk("mid_reset_write", fifo_write, 1'b0);
    chk("mid_reset_ack", ack, 5'b00000);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_release_write", fifo_write, 1'b0);
    chk("mid_release_ack", ack, 5'b00000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("mid_idle%0d_write", i), fifo_write, 1'b0);
      chk($sformatf("mid_idle%0d_ack", i), ack, 5'b00000);
    end
    @(negedge clk);
    req = 5'b00010;
    #1;
    chk("resume0_write", fifo_write, 1'b0);
    @(negedge clk);
    #1;
    chk("resume1_write", fifo_write, 1'b0);
    @(negedge clk);
    #1;
    chk("resume2_write", fifo_write, 1'b1);
    chk("resume2_item", item, 8'h11);
    chk("resume2_ack", ack, 5'b00000);
    @(negedge clk);
    #1;
    chk("resume3_write", fifo_write, 1'b0);
    chk("resume3_ack", ack, 5'b00010);

    // Fairness: every port re-requests as soon as it sees its ack.
    @(negedge clk);
    reset = 1'b0;
    req   = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < PC; k++) begin
      cnt[k]     = 0;
      tog_cyc[k] = 0;
    end
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      for (int k = 0; k < PC; k++) begin
        if (req[k] == ack[k]) begin
          req[k]     = ~req[k];
          tog_cyc[k] = c;
        end
      end
      #1;
      if (fifo_write) begin
        p = -1;
        for (int k = 0; k < PC; k++) if (item == port_data[k]) p = k;
        chk_range($sformatf("fair_c%0d_port", c), p, 0, PC - 1);
        if (p >= 0) begin
          cnt[p]++;
          chk_range($sformatf("fair_c%0d_wait_p%0d", c, p), c - tog_cyc[p] - 2, 0, PC - 1);
        end
      end
    end
    for (int k = 0; k < PC; k++) chk_range($sformatf("fair_count_p%0d", k), cnt[k], 19, 21);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
